mem_txn_scheduler: RTL and testbench

- Multi-cycle transaction scheduler that shares one single-port RAM between core 0 and core 1.
- Sits between the two core memory stages and the shared data RAM.
- Per-core req/ack handshake with latched operands, two-way round-robin arbitration, a fixed-latency RAM read pipeline, and bus locking for back-to-back read-modify-write sequences.

---
 rtl/mem_sched_pkg.sv | 19 +
 rtl/rr_lock_picker.sv | 29 ++
 rtl/mem_txn_scheduler.sv | 172 +++++++++++++++++
 tb/tb_mem_txn_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the two-core memory transaction scheduler.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic CORE0  = 1'b0;
  localparam logic CORE1  = 1'b1;
  localparam int   STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_lock_picker.sv
// Two-way round-robin winner selection; a held lock restricts the choice to its owner.
module rr_lock_picker
  import mem_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = CORE0;
    if (lock_valid) begin
      grant_valid = req[lock_owner];
      grant_id    = lock_owner;
    end else begin
      case (req)
        2'b01: begin grant_valid = 1'b1; grant_id = CORE0;       end
        2'b10: begin grant_valid = 1'b1; grant_id = CORE1;       end
        2'b11: begin grant_valid = 1'b1; grant_id = ~last_grant; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_txn_scheduler.sv
// Shares one single-port RAM between two cores: req/ack handshake, round-robin, bus lock.
// Optional grant/conflict statistics ports when MEM_SCHED_STATS_EN is defined.
module mem_txn_scheduler
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic              c0_we,
  input  logic              c0_lock,
  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  input  logic              c1_we,
  input  logic              c1_lock,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
`ifdef MEM_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] c0_grant_cnt,
  output logic [STAT_W-1:0] c1_grant_cnt,
  output logic [STAT_W-1:0] conflict_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_t              r_state, w_next_state;
  logic                r_last_grant;
  logic                r_lock_valid;
  logic [CNT_W-1:0]    r_lock_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic                r_lock;
  logic [DATA_W-1:0]   r_rdata;
  logic [LAT_W-1:0]    r_wait_cnt;
  logic                w_grant_valid;
  logic                w_grant_id;
  logic                w_wait_last;

  rr_lock_picker u_picker (
    .req         ({c1_req, c0_req}),
    .last_grant  (r_last_grant),
    .lock_valid  (r_lock_valid),
    .lock_owner  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_wait_last = (r_wait_cnt == LAT_W'(RD_LAT - 1));

  always_comb begin
    w_next_state = r_state;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    c0_ack       = 1'b0;
    c1_ack       = 1'b0;
    c0_rdata     = '0;
    c1_rdata     = '0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE:  if (w_grant_valid) w_next_state = ISSUE;
      ISSUE: begin
        ram_en       = 1'b1;
        ram_we       = r_we;
        ram_addr     = r_addr;
        ram_wdata    = r_wdata;
        w_next_state = r_we ? DONE : WAIT;
      end
      WAIT:  if (w_wait_last) w_next_state = DONE;
      DONE: begin
        if (r_last_grant == CORE0) begin
          c0_ack   = 1'b1;
          c0_rdata = r_rdata;
        end else begin
          c1_ack   = 1'b1;
          c1_rdata = r_rdata;
        end
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= CORE1;
      r_lock_valid <= 1'b0;
      r_lock_cnt   <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_lock       <= 1'b0;
      r_rdata      <= '0;
      r_wait_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_last_grant <= w_grant_id;
            r_addr       <= (w_grant_id == CORE1) ? c1_addr  : c0_addr;
            r_wdata      <= (w_grant_id == CORE1) ? c1_wdata : c0_wdata;
            r_we         <= (w_grant_id == CORE1) ? c1_we    : c0_we;
            r_lock       <= (w_grant_id == CORE1) ? c1_lock  : c0_lock;
            r_rdata      <= '0;
            r_wait_cnt   <= '0;
          end else if (r_lock_valid) begin
            // Owner let go of req while holding the lock: release it at once.
            r_lock_valid <= 1'b0;
            r_lock_cnt   <= '0;
          end
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_wait_last) r_rdata <= ram_rdata;
        end
        DONE: begin
          if (r_lock && (int'(r_lock_cnt) + 1 < MAX_LOCK)) begin
            r_lock_valid <= 1'b1;
            r_lock_cnt   <= r_lock_cnt + 1'b1;
          end else begin
            r_lock_valid <= 1'b0;
            r_lock_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_SCHED_STATS_EN
  logic [STAT_W-1:0] r_c0_grant_cnt, r_c1_grant_cnt, r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c0_grant_cnt <= '0;
      r_c1_grant_cnt <= '0;
      r_conflict_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (c0_req && c1_req) r_conflict_cnt <= sat_inc(r_conflict_cnt);
      if (w_grant_valid && (w_grant_id == CORE0)) r_c0_grant_cnt <= sat_inc(r_c0_grant_cnt);
      if (w_grant_valid && (w_grant_id == CORE1)) r_c1_grant_cnt <= sat_inc(r_c1_grant_cnt);
    end
  end

  assign c0_grant_cnt = r_c0_grant_cnt;
  assign c1_grant_cnt = r_c1_grant_cnt;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_mem_txn_scheduler.sv
// Bench for mem_txn_scheduler: RAM model, transaction-level reference model, directed scenarios.
// Statistics checks are compiled in when MEM_SCHED_STATS_EN is defined.
module tb_mem_txn_scheduler;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int RD_LAT   = 2;
  localparam int MAX_LOCK = 2;

  logic          clk;
  logic          rst_n;
  logic          c0_req, c0_we, c0_lock, c1_req, c1_we, c1_lock;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_ack, c1_ack;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          busy;
`ifdef MEM_SCHED_STATS_EN
  logic [15:0]   c0_grant_cnt, c1_grant_cnt, conflict_cnt;
  bit            stat_watch = 0;
`endif

  mem_txn_scheduler #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_we(c0_we), .c0_lock(c0_lock),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_we(c1_we), .c1_lock(c1_lock),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c1_ack(c1_ack), .c1_rdata(c1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
`ifdef MEM_SCHED_STATS_EN
    , .c0_grant_cnt(c0_grant_cnt), .c1_grant_cnt(c1_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with RD_LAT cycles of read latency
  logic [DW-1:0] ram_mem [256] = '{default: '0};
  logic [DW-1:0] rd_pipe [RD_LAT] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
    rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr[7:0]] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks cycles since the grant and derives every output from that.
  int          m_t = 0, m_last = 1, m_lockc = 0, m_own = 0, m_cf = 0, m_g0 = 0, m_g1 = 0;
  logic        m_we = 0, m_lock = 0, m_lockv = 0;
  logic [31:0] m_addr = 0, m_wd = 0, m_rdv = 0;
  logic [31:0] ref_mem [256] = '{default: '0};
  int          cyc_cnt = 0;
  int          ack_log[$];

  initial begin : compare
    int dt, g;
    logic e_en, e_we, e_ack0, e_ack1, e_busy;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (!rst_n) begin
        m_t = 0; m_last = 1; m_lockv = 0; m_lockc = 0; m_cf = 0; m_g0 = 0; m_g1 = 0;
      end
      dt     = m_we ? 2 : RD_LAT + 2;
      e_busy = (m_t != 0);
      e_en   = (m_t == 1);
      e_we   = e_en && m_we;
      e_addr = e_en ? m_addr : 32'h0;
      e_wd   = e_en ? m_wd : 32'h0;
      e_ack0 = (m_t != 0) && (m_t == dt) && (m_own == 0);
      e_ack1 = (m_t != 0) && (m_t == dt) && (m_own == 1);
      e_rd0  = (e_ack0 && !m_we) ? m_rdv : 32'h0;
      e_rd1  = (e_ack1 && !m_we) ? m_rdv : 32'h0;
      chk("m_busy",      64'(busy),      64'(e_busy));
      chk("m_ram_en",    64'(ram_en),    64'(e_en));
      chk("m_ram_we",    64'(ram_we),    64'(e_we));
      chk("m_ram_addr",  64'(ram_addr),  64'(e_addr));
      chk("m_ram_wdata", 64'(ram_wdata), 64'(e_wd));
      chk("m_c0_ack",    64'(c0_ack),    64'(e_ack0));
      chk("m_c1_ack",    64'(c1_ack),    64'(e_ack1));
      chk("m_c0_rdata",  64'(c0_rdata),  64'(e_rd0));
      chk("m_c1_rdata",  64'(c1_rdata),  64'(e_rd1));
      chk("dual_ack",    64'(c0_ack & c1_ack), 64'(0));
`ifdef MEM_SCHED_STATS_EN
      chk("m_c0_grant_cnt", 64'(c0_grant_cnt), 64'(m_g0));
      chk("m_c1_grant_cnt", 64'(c1_grant_cnt), 64'(m_g1));
      chk("m_conflict_cnt", 64'(conflict_cnt), 64'(m_cf));
`endif
      if (rst_n && c0_ack) begin
        ack_log.push_back(0);
        $display("txn core0 ack cycle=%0d rdata=0x%08h", cyc_cnt, c0_rdata);
      end
      if (rst_n && c1_ack) begin
        ack_log.push_back(1);
        $display("txn core1 ack cycle=%0d rdata=0x%08h", cyc_cnt, c1_rdata);
      end
`ifdef MEM_SCHED_STATS_EN
      if (stat_watch && (c0_ack || c1_ack) && ack_log.size() == 5) begin
        chk("stat_c0_grants_lit", 64'(c0_grant_cnt), 64'(3));
        chk("stat_c1_grants_lit", 64'(c1_grant_cnt), 64'(2));
        chk("stat_conflicts_lit", 64'(conflict_cnt), 64'(5));
      end
`endif
      if (rst_n) begin
        if (m_t == 0) begin
          g = -1;
          if (c0_req && c1_req) m_cf = (m_cf < 65535) ? m_cf + 1 : m_cf;
          if (m_lockv) begin
            if ((m_last == 0) ? c0_req : c1_req) g = m_last;
            else begin m_lockv = 0; m_lockc = 0; end
          end else if (c0_req && c1_req) g = 1 - m_last;
          else if (c0_req) g = 0;
          else if (c1_req) g = 1;
          if (g >= 0) begin
            m_we   = (g == 0) ? c0_we    : c1_we;
            m_addr = (g == 0) ? c0_addr  : c1_addr;
            m_wd   = (g == 0) ? c0_wdata : c1_wdata;
            m_lock = (g == 0) ? c0_lock  : c1_lock;
            m_last = g; m_own = g; m_t = 1;
            if (m_we) begin ref_mem[m_addr[7:0]] = m_wd; m_rdv = 0; end
            else m_rdv = ref_mem[m_addr[7:0]];
            if (g == 0) m_g0 = (m_g0 < 65535) ? m_g0 + 1 : m_g0;
            else        m_g1 = (m_g1 < 65535) ? m_g1 + 1 : m_g1;
          end
        end else if (m_t == dt) begin
          if (m_lock && (m_lockc + 1 < MAX_LOCK)) begin m_lockv = 1; m_lockc++; end
          else begin m_lockv = 0; m_lockc = 0; end
          m_t = 0;
        end else m_t++;
      end
    end
  end

  // Per-core operation lists replayed by a cycle-based driver
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic lock; int gap; } op_t;
  op_t ops0[$], ops1[$];
  int  d_idx[2], d_gap[2];
  bit  d_act[2], d_ackd[2];

  task automatic add_op(input int c, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic lk, input int gap);
    op_t o;
    o.we = we; o.addr = a; o.wdata = wd; o.lock = lk; o.gap = gap;
    if (c == 0) ops0.push_back(o); else ops1.push_back(o);
  endtask

  task automatic drive_step(input int c);
    int  n;
    op_t o;
    n = (c == 0) ? ops0.size() : ops1.size();
    if (d_act[c] && d_ackd[c]) begin
      d_act[c] = 0;
      d_idx[c]++;
      d_gap[c] = 0;
      if (d_idx[c] < n) d_gap[c] = (c == 0) ? ops0[d_idx[c]].gap : ops1[d_idx[c]].gap;
    end
    if (!d_act[c]) begin
      if (d_idx[c] < n && d_gap[c] == 0) begin
        o = (c == 0) ? ops0[d_idx[c]] : ops1[d_idx[c]];
        if (c == 0) begin c0_req = 1; c0_we = o.we; c0_addr = o.addr; c0_wdata = o.wdata; c0_lock = o.lock; end
        else        begin c1_req = 1; c1_we = o.we; c1_addr = o.addr; c1_wdata = o.wdata; c1_lock = o.lock; end
        d_act[c] = 1;
      end else begin
        if (c == 0) c0_req = 0; else c1_req = 0;
        if (d_gap[c] > 0) d_gap[c]--;
      end
    end
  endtask

  task automatic run_ops(input int budget);
    int cyc = 0;
    for (int c = 0; c < 2; c++) begin
      d_idx[c] = 0; d_act[c] = 0; d_ackd[c] = 0; d_gap[c] = 0;
    end
    if (ops0.size() > 0) d_gap[0] = ops0[0].gap;
    if (ops1.size() > 0) d_gap[1] = ops1[0].gap;
    drive_step(0); drive_step(1);
    while ((d_idx[0] < ops0.size() || d_idx[1] < ops1.size()) && cyc < budget) begin
      @(negedge clk);
      d_ackd[0] = c0_ack; d_ackd[1] = c1_ack;
      @(posedge clk); #1;
      drive_step(0); drive_step(1);
      cyc++;
    end
    if (cyc >= budget) begin
      n_vec++; n_err++;
      $display("FAIL run_ops_timeout: %0d cycles without completing, limit %0d", cyc, budget);
    end
  endtask

  task automatic check_order(input string name, input int exp_q[$]);
    chk({name, "_count"}, 64'(ack_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ack_log.size(); i++)
      chk($sformatf("%s_%0d", name, i), 64'(ack_log[i]), 64'(exp_q[i]));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; c0_req = 0; c1_req = 0; c0_lock = 0; c1_lock = 0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : main
    rst_n = 0;
    c0_req = 0; c0_we = 0; c0_lock = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_lock = 0; c1_addr = '0; c1_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   64'(busy),   64'(0));
    chk("rst_ram_en", 64'(ram_en), 64'(0));
    chk("rst_acks",   64'({c0_ack, c1_ack}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1;

    // Single write from core 0
    c0_req = 1; c0_we = 1; c0_addr = 32'h10; c0_wdata = 32'hDEADBEEF;
    @(negedge clk); chk("wr_g_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("wr_g1_ram_en",   64'(ram_en),   64'(1));
    chk("wr_g1_ram_we",   64'(ram_we),   64'(1));
    chk("wr_g1_ram_addr", 64'(ram_addr), 64'h10);
    chk("wr_g1_busy",     64'(busy),     64'(1));
    chk("wr_g1_ack",      64'(c0_ack),   64'(0));
    @(negedge clk);
    chk("wr_g2_ack",   64'(c0_ack),   64'(1));
    chk("wr_g2_busy",  64'(busy),     64'(1));
    chk("wr_g2_rdata", 64'(c0_rdata), 64'(0));
    @(posedge clk); #1; c0_req = 0; c0_we = 0;
    @(negedge clk); chk("wr_g3_busy", 64'(busy), 64'(0));

    // Read back from core 1
    @(posedge clk); #1; c1_req = 1; c1_we = 0; c1_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    chk("rd_g1_ram_en", 64'(ram_en), 64'(1));
    chk("rd_g1_ram_we", 64'(ram_we), 64'(0));
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rd_g%0d_ack", k),   64'(c1_ack),   64'(0));
      chk($sformatf("rd_g%0d_rdata", k), 64'(c1_rdata), 64'(0));
    end
    @(negedge clk);
    chk("rd_g4_ack",   64'(c1_ack),   64'(1));
    chk("rd_g4_rdata", 64'(c1_rdata), 64'hDEADBEEF);
    @(posedge clk); #1; c1_req = 0;

    // Contention from reset: writes alternate starting with core 0
    do_reset();
    ops0.delete(); ops1.delete(); ack_log.delete();
    for (int i = 0; i < 3; i++) begin
      add_op(0, 1, 32'h40 + 32'(i), 32'hA0A0_0000 + 32'(i), 0, 0);
      add_op(1, 1, 32'h50 + 32'(i), 32'hB0B0_0000 + 32'(i), 0, 0);
    end
`ifdef MEM_SCHED_STATS_EN
    stat_watch = 1;
`endif
    run_ops(300);
`ifdef MEM_SCHED_STATS_EN
    stat_watch = 0;
`endif
    check_order("contend", '{0, 1, 0, 1, 0, 1});

    // Lock capped at two transactions while core 1 waits
    do_reset();
    ops0.delete(); ops1.delete(); ack_log.delete();
    add_op(0, 0, 32'h10, 32'h0, 1, 0);
    add_op(0, 1, 32'h20, 32'h1111_1111, 1, 0);
    add_op(0, 1, 32'h30, 32'h2222_2222, 1, 0);
    add_op(1, 1, 32'h60, 32'h3333_3333, 0, 0);
    run_ops(300);
    check_order("lock_cap", '{0, 0, 1, 0});

    // Dropping req for one idle cycle releases the lock
    do_reset();
    ops0.delete(); ops1.delete(); ack_log.delete();
    add_op(0, 0, 32'h20, 32'h0, 1, 0);
    add_op(0, 1, 32'h70, 32'h4444_4444, 0, 1);
    add_op(1, 1, 32'h74, 32'h5555_5555, 0, 0);
    run_ops(300);
    check_order("lock_release", '{0, 1, 0});

    // Reset during a read WAIT abandons it; the retried read completes normally
    c0_req = 1; c0_we = 0; c0_lock = 0; c0_addr = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("wait_rst%0d_busy", k), 64'(busy),   64'(0));
      chk($sformatf("wait_rst%0d_en", k),   64'(ram_en), 64'(0));
      chk($sformatf("wait_rst%0d_ack", k),  64'(c0_ack), 64'(0));
      @(posedge clk); #1;
    end
    rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ram_en",   64'(ram_en),   64'(1));
    chk("post_rst_ram_addr", 64'(ram_addr), 64'h20);
    @(negedge clk); chk("post_rst_g2_ack", 64'(c0_ack), 64'(0));
    @(negedge clk); chk("post_rst_g3_ack", 64'(c0_ack), 64'(0));
    @(negedge clk);
    chk("post_rst_g4_ack",   64'(c0_ack),   64'(1));
    chk("post_rst_g4_rdata", 64'(c0_rdata), 64'h1111_1111);
    @(posedge clk); #1; c0_req = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
